chain_score_max: RTL and testbench



---
 rtl/chain_score_max_if.sv | 33 +++
 rtl/chain_score_max.sv | 188 ++++++++++++++++++
 tb/tb_chain_score_max.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chain_score_max_if.sv
// Pair-in / group-result-out bus for chain_score_max.
// The master drives pairs, the quasi-static W/W_avg and out_ready; the slave
// (the scoring unit) drives in_ready and the group result.
interface chain_score_max_if #(
  parameter int COORD_W = 32,
  parameter int SCORE_W = 32,
  parameter int IDX_W   = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [COORD_W-1:0]        in_i_x;
  logic [COORD_W-1:0]        in_i_y;
  logic [COORD_W-1:0]        in_j_x;
  logic [COORD_W-1:0]        in_j_y;
  logic                      in_last;
  logic [COORD_W-1:0]        W;
  logic [COORD_W-1:0]        W_avg;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [SCORE_W-1:0] out_score;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_found;

  modport master (
    output in_valid, in_i_x, in_i_y, in_j_x, in_j_y, in_last, W, W_avg, out_ready,
    input  in_ready, out_valid, out_score, out_idx, out_found
  );

  modport slave (
    input  in_valid, in_i_x, in_i_y, in_j_x, in_j_y, in_last, W, W_avg, out_ready,
    output in_ready, out_valid, out_score, out_idx, out_found
  );
endinterface

// File: rtl/chain_score_max.sv
// Three-stage chaining score unit: stage 1 forms dx/dy and the validity flag,
// stage 2 forms alpha and the gap penalty beta, stage 3 forms the saturated
// score and folds it into a per-group running maximum. The group result is
// held in an output register until the downstream side accepts it.
module chain_score_max #(
  parameter int COORD_W   = 32,
  parameter int SCORE_W   = 32,
  parameter int IDX_W     = 8,
  parameter int MAX_DIST  = 5000,
  parameter int AVG_SHIFT = 7
) (
  input logic clk,
  input logic reset,
  chain_score_max_if.slave bus
);
  localparam int CW1    = COORD_W + 1;
  localparam int GAP_W  = COORD_W + 2;
  localparam int PROD_W = GAP_W + COORD_W;
  localparam int WIDE_W = PROD_W + 2;

  localparam logic signed [SCORE_W-1:0] NEG_INF = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] NEG_SAT = {1'b1, {(SCORE_W-2){1'b0}}, 1'b1};
  localparam logic signed [SCORE_W-1:0] POS_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0]  POS_MAX_W = $signed({{(WIDE_W-SCORE_W){1'b0}}, POS_MAX});
  localparam logic signed [WIDE_W-1:0]  NEG_SAT_W = $signed({{(WIDE_W-SCORE_W){1'b1}}, NEG_SAT});
  localparam logic signed [CW1-1:0]     ZERO_C     = {CW1{1'b0}};
  localparam logic signed [CW1-1:0]     MAX_DIST_C = CW1'(MAX_DIST);
  localparam logic [IDX_W-1:0]          IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]          IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]          IDX_MAX    = {IDX_W{1'b1}};

  // Position of the highest set bit; only meaningful for a non-zero gap.
  function automatic logic [PROD_W-1:0] floor_log2(input logic [GAP_W-1:0] v);
    floor_log2 = {PROD_W{1'b0}};
    for (int b = 0; b < GAP_W; b++) begin
      floor_log2 = v[b] ? PROD_W'(b) : floor_log2;
    end
  endfunction

  // Pipeline and accumulator state
  logic                      s1_valid_q, s1_valid_d, s1_ok_q, s1_ok_d, s1_last_q, s1_last_d;
  logic signed [CW1-1:0]     s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic                      s2_valid_q, s2_valid_d, s2_ok_q, s2_ok_d, s2_last_q, s2_last_d;
  logic signed [CW1-1:0]     s2_alpha_q, s2_alpha_d;
  logic [PROD_W-1:0]         s2_beta_q, s2_beta_d;
  logic signed [SCORE_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d, cnt_q, cnt_d;
  logic                      found_q, found_d;
  logic                      out_valid_q, out_valid_d, out_found_q, out_found_d;
  logic signed [SCORE_W-1:0] out_score_q, out_score_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;

  // Stage 1: signed displacements of the incoming pair and its validity.
  logic signed [CW1-1:0] dx_s, dy_s;
  logic                  ok_s;
  always_comb begin
    dx_s = $signed({1'b0, bus.in_i_x}) - $signed({1'b0, bus.in_j_x});
    dy_s = $signed({1'b0, bus.in_i_y}) - $signed({1'b0, bus.in_j_y});
    ok_s = (dx_s > ZERO_C) && (dy_s > ZERO_C) && (dx_s <= MAX_DIST_C) && (dy_s <= MAX_DIST_C);
  end

  // Stage 2: seed-span credit alpha and gap penalty beta.
  logic signed [CW1-1:0]   min_xy_s, w_s, alpha_s;
  logic signed [GAP_W-1:0] diff_s;
  logic [GAP_W-1:0]        gap_s;
  logic [PROD_W-1:0]       prod_s, beta_s;
  always_comb begin
    min_xy_s = (s1_dx_q < s1_dy_q) ? s1_dx_q : s1_dy_q;
    w_s      = $signed({1'b0, bus.W});
    alpha_s  = (w_s < min_xy_s) ? w_s : min_xy_s;
    diff_s   = $signed({s1_dx_q[CW1-1], s1_dx_q}) - $signed({s1_dy_q[CW1-1], s1_dy_q});
    gap_s    = diff_s[GAP_W-1] ? $unsigned(-diff_s) : $unsigned(diff_s);
    prod_s   = PROD_W'(gap_s) * PROD_W'(bus.W_avg);
    if (gap_s == {GAP_W{1'b0}}) begin
      beta_s = {PROD_W{1'b0}};
    end else begin
      beta_s = (prod_s >> AVG_SHIFT) + (floor_log2(gap_s) >> 1'b1);
    end
  end

  // Stage 3: saturated score and comparison against the running maximum.
  logic signed [WIDE_W-1:0]  diff_w_s;
  logic signed [SCORE_W-1:0] score_s, cand_max_s;
  logic [IDX_W-1:0]          cand_idx_s;
  logic                      cand_found_s, better_s;
  always_comb begin
    diff_w_s = $signed({{(WIDE_W-CW1){s2_alpha_q[CW1-1]}}, s2_alpha_q}) - $signed({2'b00, s2_beta_q});
    if (!s2_ok_q) begin
      score_s = NEG_INF;
    end else if (diff_w_s > POS_MAX_W) begin
      score_s = POS_MAX;
    end else if (diff_w_s < NEG_SAT_W) begin
      score_s = NEG_SAT;
    end else begin
      score_s = diff_w_s[SCORE_W-1:0];
    end
    better_s     = (score_s > max_q);
    cand_max_s   = better_s ? score_s : max_q;
    cand_idx_s   = better_s ? cnt_q : best_idx_q;
    cand_found_s = found_q | s2_ok_q;
  end

  // Flow control: only a group end blocked by an unaccepted result stalls.
  logic stall_s, retire_s, close_s;
  always_comb begin
    stall_s  = out_valid_q && !bus.out_ready && s2_valid_q && s2_last_q;
    retire_s = s2_valid_q && !stall_s;
    close_s  = retire_s && s2_last_q;
  end

  // Next-state: advance the pipeline, fold retiring pairs, manage the result.
  always_comb begin
    s1_valid_d = s1_valid_q; s1_ok_d = s1_ok_q; s1_last_d = s1_last_q;
    s1_dx_d = s1_dx_q; s1_dy_d = s1_dy_q;
    s2_valid_d = s2_valid_q; s2_ok_d = s2_ok_q; s2_last_d = s2_last_q;
    s2_alpha_d = s2_alpha_q; s2_beta_d = s2_beta_q;
    max_d = max_q; best_idx_d = best_idx_q; cnt_d = cnt_q; found_d = found_q;
    out_valid_d = out_valid_q; out_score_d = out_score_q;
    out_idx_d = out_idx_q; out_found_d = out_found_q;

    if (!stall_s) begin
      s1_valid_d = bus.in_valid;
      s1_ok_d    = ok_s;
      s1_last_d  = bus.in_last;
      s1_dx_d    = dx_s;
      s1_dy_d    = dy_s;
      s2_valid_d = s1_valid_q;
      s2_ok_d    = s1_ok_q;
      s2_last_d  = s1_last_q;
      s2_alpha_d = alpha_s;
      s2_beta_d  = beta_s;
    end else begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
    end

    if (close_s) begin
      out_score_d = cand_max_s;
      out_idx_d   = cand_idx_s;
      out_found_d = cand_found_s;
      max_d       = NEG_INF;
      best_idx_d  = IDX_ZERO;
      cnt_d       = IDX_ZERO;
      found_d     = 1'b0;
    end else if (retire_s) begin
      max_d      = cand_max_s;
      best_idx_d = cand_idx_s;
      found_d    = cand_found_s;
      cnt_d      = (cnt_q == IDX_MAX) ? cnt_q : (cnt_q + IDX_ONE);
    end else begin
      max_d = max_q;
    end

    if (close_s) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset that drops every in-flight pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0; s1_ok_q <= 1'b0; s1_last_q <= 1'b0;
      s1_dx_q <= ZERO_C; s1_dy_q <= ZERO_C;
      s2_valid_q <= 1'b0; s2_ok_q <= 1'b0; s2_last_q <= 1'b0;
      s2_alpha_q <= ZERO_C; s2_beta_q <= {PROD_W{1'b0}};
      max_q <= NEG_INF; best_idx_q <= IDX_ZERO; cnt_q <= IDX_ZERO; found_q <= 1'b0;
      out_valid_q <= 1'b0; out_score_q <= NEG_INF; out_idx_q <= IDX_ZERO; out_found_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d; s1_ok_q <= s1_ok_d; s1_last_q <= s1_last_d;
      s1_dx_q <= s1_dx_d; s1_dy_q <= s1_dy_d;
      s2_valid_q <= s2_valid_d; s2_ok_q <= s2_ok_d; s2_last_q <= s2_last_d;
      s2_alpha_q <= s2_alpha_d; s2_beta_q <= s2_beta_d;
      max_q <= max_d; best_idx_q <= best_idx_d; cnt_q <= cnt_d; found_q <= found_d;
      out_valid_q <= out_valid_d; out_score_q <= out_score_d;
      out_idx_q <= out_idx_d; out_found_q <= out_found_d;
    end
  end

  assign bus.in_ready  = !stall_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_score = out_score_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_found = out_found_q;
endmodule

// File: tb/tb_chain_score_max.sv
// Scoreboard bench for chain_score_max: the stimulus side pushes expected
// group results, a negedge monitor pops and compares on every output transfer.
module tb_chain_score_max;
  localparam int COORD_W = 32;
  localparam int SCORE_W = 32;
  localparam int IDX_W   = 8;
  localparam longint NEG_INF = -64'sd2147483648;
  localparam longint POS_MAX = 64'sd2147483647;

  typedef struct {
    longint score;
    longint idx;
    longint found;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_acc_cyc = 0;
  int     acc_count = 0;
  bit     rdy_rand = 1'b0;
  logic   rdy_level = 1'b1;
  exp_t   exp_q[$];
  exp_t   e;
  bit     held = 1'b0;
  logic signed [SCORE_W-1:0] h_score;
  logic [IDX_W-1:0]          h_idx;
  logic                      h_found;

  chain_score_max_if #(.COORD_W(COORD_W), .SCORE_W(SCORE_W), .IDX_W(IDX_W)) bus ();

  chain_score_max #(
    .COORD_W(COORD_W), .SCORE_W(SCORE_W), .IDX_W(IDX_W), .MAX_DIST(5000), .AVG_SHIFT(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream acceptance: fixed level or random back-pressure.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input longint s, input longint idx, input longint f);
    exp_t x;
    x.score = s; x.idx = idx; x.found = f;
    exp_q.push_back(x);
  endtask

  // Reference pair score straight from the scoring rules.
  function automatic void ref_pair(input longint ix, iy, jx, jy, w, wavg,
                                   output longint s, output bit v);
    longint dx, dy, alpha, gap, beta, lg;
    dx = ix - jx;
    dy = iy - jy;
    v = (dx > 0) && (dy > 0) && (dx <= 5000) && (dy <= 5000);
    if (!v) begin
      s = NEG_INF;
      return;
    end
    alpha = (dx < dy) ? dx : dy;
    if (w < alpha) alpha = w;
    gap = (dx > dy) ? dx - dy : dy - dx;
    lg = 0;
    while ((gap >> (lg + 1)) != 0) lg++;
    beta = (gap == 0) ? 0 : ((gap * wavg) >> 7) + (lg >> 1);
    s = alpha - beta;
    if (s > POS_MAX) s = POS_MAX;
    if (s < NEG_INF + 1) s = NEG_INF + 1;
  endfunction

  // Issue one pair; called and returns at posedge+1.
  task automatic send(input longint ix, iy, jx, jy, input bit last);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_i_x = ix[31:0]; bus.in_i_y = iy[31:0];
    bus.in_j_x = jx[31:0]; bus.in_j_y = jy[31:0];
    bus.in_last = last;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        last_acc_cyc = cyc;
        acc_count++;
        break;
      end
      guard++;
      if (guard > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed low for %0d cycles, expected accept", guard);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic random_group(input int n, input longint w, input longint wavg);
    longint ix, iy, jx, jy, s, best, bidx, d;
    bit v, found;
    int r;
    best = NEG_INF; bidx = 0; found = 1'b0;
    for (int k = 0; k < n; k++) begin
      ix = $urandom_range(6000, 20000);
      iy = $urandom_range(6000, 20000);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        d = $urandom_range(1, 3000);
        jx = ix - d;
        jy = iy - d - $urandom_range(0, 20);
      end else if (r < 7) begin
        jx = ix - $urandom_range(1, 5000);
        jy = iy - $urandom_range(1, 5000);
      end else if (r == 7) begin
        jx = ix;
        jy = iy - $urandom_range(1, 100);
      end else if (r == 8) begin
        jx = ix - 4999 - $urandom_range(0, 2);
        jy = iy - $urandom_range(4999, 5001);
      end else begin
        jx = ix + $urandom_range(1, 100);
        jy = iy - $urandom_range(1, 100);
      end
      ref_pair(ix, iy, jx, jy, w, wavg, s, v);
      if (s > best) begin
        best = s;
        bidx = (k > 255) ? 255 : k;
      end
      found = found | v;
      if (k == n - 1) push(best, bidx, found);
      send(ix, iy, jx, jy, k == n - 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Monitor: hold-stability and scoreboard comparison on each transfer.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_stable", (bus.out_score == h_score && bus.out_idx == h_idx &&
                              bus.out_found == h_found), 1);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got score %0d idx %0d, expected no result",
                   bus.out_score, bus.out_idx);
        end else begin
          e = exp_q.pop_front();
          check("out_score", longint'(bus.out_score), e.score);
          check("out_idx", longint'(bus.out_idx), e.idx);
          check("out_found", longint'(bus.out_found), e.found);
        end
      end else if (bus.out_valid === 1'b1) begin
        held = 1'b1;
        h_score = bus.out_score; h_idx = bus.out_idx; h_found = bus.out_found;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  longint sjx[3][3] = '{'{30, 90, 60}, '{60, 30, 90}, '{30, 90, 90}};
  longint sjy[3][3] = '{'{20, 40, 10}, '{10, 20, 40}, '{20, 40, 40}};

  initial begin
    longint w_cur, wavg_cur;
    int n;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.in_i_x = '0; bus.in_i_y = '0; bus.in_j_x = '0; bus.in_j_y = '0;
    bus.W = 32'd40; bus.W_avg = 32'd40;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_score", longint'(bus.out_score), NEG_INF);
    check("reset_out_idx", bus.out_idx, 0);
    check("reset_out_found", bus.out_found, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single pair and latency
    push(16, 0, 1);
    send(100, 50, 30, 20, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 20);
    check("latency", cyc - last_acc_cyc, 3);
    wait_drain();

    // Three-pair group and tie handling
    push(40, 2, 1);
    send(100, 50, 30, 20, 1'b0); send(100, 50, 90, 40, 1'b0); send(100, 50, 60, 10, 1'b1);
    push(16, 0, 1);
    send(100, 50, 30, 20, 1'b0); send(100, 50, 90, 40, 1'b0); send(100, 50, 90, 40, 1'b1);
    wait_drain();

    // All-invalid group
    push(NEG_INF, 0, 0);
    send(100, 50, 100, 40, 1'b0); send(6000, 6000, 0, 0, 1'b1);
    wait_drain();

    // Negative score saturation
    bus.W_avg = 32'hFFFF_FFFF;
    push(NEG_INF + 1, 0, 1);
    send(5000, 1, 0, 0, 1'b1);
    wait_drain();
    bus.W_avg = 32'd40;

    // Back-to-back groups under back-pressure
    rdy_level = 1'b0;
    acc_count = 0;
    push(40, 2, 1); push(40, 0, 1); push(16, 0, 1);
    fork
      begin
        for (int g = 0; g < 3; g++)
          for (int k = 0; k < 3; k++)
            send(100, 50, sjx[g][k], sjy[g][k], k == 2);
      end
      begin
        int m;
        m = 0;
        do begin
          @(negedge clk);
          m++;
        end while (bus.in_ready !== 1'b0 && m < 40);
        check("pairs_before_stall", acc_count, 7);
        for (int t = 0; t < 5; t++) begin
          check("stall_in_ready", bus.in_ready, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        rdy_level = 1'b1;
        @(negedge clk);
        check("release_handshake", (bus.out_valid === 1'b1 && bus.out_ready === 1'b1), 1);
        @(negedge clk);
        check("reload_no_gap", bus.out_valid, 1);
      end
    join
    wait_drain();

    // Reset in the middle of a group
    send(100, 50, 60, 10, 1'b0); send(100, 50, 60, 10, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_out_score", longint'(bus.out_score), NEG_INF);
    check("midreset_out_idx", bus.out_idx, 0);
    check("midreset_out_found", bus.out_found, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    push(10, 0, 1);
    send(50, 50, 40, 40, 1'b1);
    wait_drain();

    // Index saturation: best pair beyond the last representable index
    push(30, 255, 1);
    for (int k = 0; k < 260; k++) begin
      longint d;
      d = (k >= 258) ? 30 : 5;
      send(1000, 1000, 1000 - d, 1000 - d, k == 259);
    end
    wait_drain();

    // Randomised groups against the reference model
    for (int b = 0; b < 2; b++) begin
      w_cur    = (b == 0) ? $urandom_range(0, 3000) : $urandom_range(0, 100);
      wavg_cur = (b == 0) ? $urandom_range(0, 300) : $urandom_range(0, 20);
      bus.W = w_cur[31:0];
      bus.W_avg = wavg_cur[31:0];
      rdy_rand = 1'b1;
      for (int g = 0; g < 25; g++) random_group($urandom_range(1, 5), w_cur, wavg_cur);
      rdy_rand = 1'b0;
      rdy_level = 1'b1;
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
